mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one shared memory port, fixed-latency access.
// ARB_FIXED_PRIO_EN: A always wins ties; otherwise ties go round robin.
module mem_port_arbiter #(
  parameter int LATENCY = 2,
  parameter int W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] addr_a,
  input  logic [W-1:0] addr_b,
  input  logic [W-1:0] wdata_a,
  input  logic [W-1:0] wdata_b,
  input  logic         we_a,
  input  logic         we_b,
  input  logic [W-1:0] mem_rdata,
  output logic         sel,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         mem_en,
  output logic         mem_we,
  output logic         done_a,
  output logic         done_b,
  output logic [W-1:0] rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic           sel_q;
  logic           done_a_q;
  logic           done_b_q;
  logic [W-1:0]   rdata_q;
  logic           elig_a;
  logic           elig_b;
  logic           pick_a_d;
  logic           pick_b_d;
`ifndef ARB_FIXED_PRIO_EN
  logic           last_b_q;
`endif

  // Grant selection; a requester is masked in its own done cycle
  always_comb begin
    elig_a   = req_a & ~done_a_q;
    elig_b   = req_b & ~done_b_q;
`ifdef ARB_FIXED_PRIO_EN
    pick_b_d = elig_b & ~elig_a;
`else
    pick_b_d = elig_b & (~elig_a | ~last_b_q);
`endif
    pick_a_d = elig_a & ~pick_b_d;
  end

  // Arbitration FSM with registered select, done pulses and read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      rdata_q  <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_b_q <= 1'b1;
`endif
    end else begin
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_a_d) begin
            state_q  <= BUSY_A;
            sel_q    <= 1'b0;
            cnt_q    <= CNT_LOAD;
`ifndef ARB_FIXED_PRIO_EN
            last_b_q <= 1'b0;
`endif
          end else if (pick_b_d) begin
            state_q  <= BUSY_B;
            sel_q    <= 1'b1;
            cnt_q    <= CNT_LOAD;
`ifndef ARB_FIXED_PRIO_EN
            last_b_q <= 1'b1;
`endif
          end
        end
        BUSY_A: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q  <= IDLE;
            done_a_q <= 1'b1;
            if (!we_a) rdata_q <= mem_rdata;
          end
        end
        BUSY_B: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q  <= IDLE;
            done_b_q <= 1'b1;
            if (!we_b) rdata_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel       = sel_q;
  assign mem_en    = (state_q == BUSY_A) | (state_q == BUSY_B);
  assign mem_addr  = sel_q ? addr_b : addr_a;
  assign mem_wdata = sel_q ? wdata_b : wdata_a;
  assign mem_we    = mem_en & (sel_q ? we_b : we_a);
  assign done_a    = done_a_q;
  assign done_b    = done_b_q;
  assign rdata     = rdata_q;

endmodule
